rca_tpg_bist: RTL
=================

# rca_tpg_bist

Parametrised test-pattern generator and response checker for a WIDTH-bit ripple-carry adder under BIST. It drives adder operands `a`, `b` and carry-in `c_1` through one of two pattern sequences. It compares the adder's sum against the golden value and reports pass/fail through a start/done handshake. It sits between the BIST controller and the adder under test, in the same position as the existing fixed 5-bit generator, which it replaces.

## Interface
- `WIDTH`, 5: adder operand width; legal range 2..12.
- `CNT_W`, 8: width of the saturating fail counter.
- `IDX_W`, 2*WIDTH+1: pattern index width (derived; do not override).
- `clk`  in  1  sole clock, rising edge.
- `init`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin a run; honoured only in IDLE or DONE.
- `mode`  in  1  0 = C-test (8 patterns), 1 = exhaustive count (2^IDX_W patterns); sampled with `start`.
- `hold`  in  1  stall; freezes pattern, index and checker.
- `sum_in`  in  WIDTH+1  adder result for the currently driven pattern (combinational adder, same cycle).
- `a`, `b`  out  WIDTH  registered operands.
- `c_1`  out  1  registered carry-in.
- `valid`  out  1  a/b/c_1 hold a live pattern.
- `busy`  out  1  run in progress.
- `done`  out  1  sticky run complete.
- `fail`  out  1  sticky, at least one mismatch this run.
- `fail_cnt`  out  CNT_W  mismatches this run, saturates at all-ones.
- `first_fail_idx`  out  IDX_W  index of first mismatching pattern; 0 if none.

## Operation
- FSM states IDLE, RUN, DONE.
  - IDLE→RUN on `start`.
  - RUN→DONE after the last pattern is checked.
  - DONE→RUN on `start`.
  - `init` from any state → IDLE.
- Entering RUN:
  - latch `mode`; index k=0; present pattern 0;
  - clear `fail`, `fail_cnt`, `first_fail_idx`, `done`.
- Mode 0 (C-test), k=0..7, with k2,k1,k0 the bits of k:
  - `c_1`=k0.
  - Even bit i: a_i=k2, b_i=k1.
  - Odd bit i: a_i = k2 | (k1 & ~k0); b_i = (k2 & (~k1 | k0)) | (k1 & k0).
- Mode 1 (exhaustive), k=0..2^IDX_W−1:
  - `c_1`=k[0];
  - `b`=k[WIDTH:1];
  - `a`=k[2*WIDTH:WIDTH+1].
- Check cycle: any cycle with `valid`=1 and `hold`=0.
  - Golden = a+b+c_1, WIDTH+1 bits, no truncation.
  - Mismatch → `fail`=1; `fail_cnt`+1 (saturating).
  - First mismatch only → `first_fail_idx`=k.
- Hold cycles perform no comparison, so a stalled pattern is never counted twice.
- `start` while in RUN is ignored; `mode` changes mid-run are ignored.

## Timing
- Reset (async, immediate): state IDLE, k=0, all outputs 0.
- `start` sampled at edge T → at T+1 `busy`=1, `valid`=1, pattern 0 on outputs.
- One pattern per cycle when `hold`=0. A pattern stays on the outputs for 1+H cycles, where H is the number of hold cycles.
- Last pattern (k=7 or 2^IDX_W−1) checked at edge E. At E+1:
  - `valid`=0, `busy`=0, `done`=1;
  - `a`/`b`/`c_1` return to 0.
- Run latency: 8 cycles (mode 0) or 2^IDX_W cycles (mode 1), plus hold cycles, from first pattern to `done`.
- `fail`, `fail_cnt` and `first_fail_idx` are final in the cycle `done` rises. They stay stable through DONE until the next `start` or `init`.
- `init` mid-run aborts: no `done`; all counters and flags cleared.
- Index wrap: k never wraps. The terminal count ends the run.
- `start` and `hold` in the same cycle in IDLE/DONE: `start` wins. `hold` applies from the first RUN cycle.

## Test plan
- Mode 0, WIDTH=5, `sum_in` driven correctly. Required:
  - at k=3: a=00000, b=11111, c_1=1, golden sum 32;
  - at k=4: a=11111, b=01010, c_1=0, golden sum 41;
  - `done` exactly 8 cycles after the first `valid`; `fail`=0, `fail_cnt`=0.
- Mode 1, WIDTH=2: a 32-pattern run.
  - k=31 gives a=3, b=3, c_1=1.
  - `done` rises the cycle after k=31; no wrap to k=0.
- Fault injection:
  - Force `sum_in` bit 0 wrong for k=5 and k=6 in mode 0 → `fail`=1, `fail_cnt`=2, `first_fail_idx`=5.
  - Force every pattern wrong with CNT_W=2 → `fail_cnt` saturates at 3.
- `hold` high for 3 cycles at k=2 in mode 0:
  - pattern k=2 is visible for 4 cycles;
  - a single mismatch during that window increments `fail_cnt` by exactly 1;
  - total run is 11 cycles.
- Re-`start` and abort:
  - `start` pulsed at k=4 → ignored, run continues.
  - `init` asserted at k=6 → outputs 0 immediately, `done` stays 0.
  - A new `start` restarts at k=0 with flags cleared.

Source files
------------

// File: rtl/rca_tpg_bist_if.sv
// rtl/rca_tpg_bist_if.sv - handshake and adder-side bus of the ripple-carry adder BIST pattern generator
//
// Purpose: bundles the controller handshake (start/mode/hold -> busy/valid/done
// plus result flags) with the adder-under-test connections (a/b/c_1 out, sum_in back).
// Ports (as seen by the generator, modport slave):
//   start, mode, hold   in   run request, pattern set select, stall
//   sum_in              in   WIDTH+1 adder result for the driven pattern
//   a, b, c_1           out  operands and carry-in
//   valid, busy, done   out  pattern live, run in progress, run complete
//   fail, fail_cnt      out  mismatch flag and saturating mismatch count
//   first_fail_idx      out  index of the first mismatching pattern
`timescale 1ns/1ps
interface rca_tpg_bist_if #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8
);
  localparam int IDX_W = 2 * WIDTH + 1;

  logic             start;
  logic             mode;
  logic             hold;
  logic [WIDTH:0]   sum_in;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_1;
  logic             valid;
  logic             busy;
  logic             done;
  logic             fail;
  logic [CNT_W-1:0] fail_cnt;
  logic [IDX_W-1:0] first_fail_idx;

  modport master (
    output start, mode, hold, sum_in,
    input  a, b, c_1, valid, busy, done, fail, fail_cnt, first_fail_idx
  );

  modport slave (
    input  start, mode, hold, sum_in,
    output a, b, c_1, valid, busy, done, fail, fail_cnt, first_fail_idx
  );
endinterface

// File: rtl/rca_tpg_bist.sv
// rtl/rca_tpg_bist.sv - test-pattern generator and response checker for a WIDTH-bit ripple-carry adder
//
// Purpose: walks either the 8-pattern C-test or an exhaustive count over
// {a, b, c_1}, compares the adder's sum each non-stalled cycle and reports
// sticky pass/fail results through a start/done handshake.
// Ports:
//   clk   in  rising-edge clock
//   init  in  asynchronous active-high reset
//   bus   rca_tpg_bist_if.slave (start/mode/hold/sum_in in; a/b/c_1, valid,
//         busy, done, fail, fail_cnt, first_fail_idx out)
`timescale 1ns/1ps
module rca_tpg_bist #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8,
  localparam int IDX_W = 2 * WIDTH + 1
) (
  input  logic          clk,
  input  logic          init,
  rca_tpg_bist_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] k;
  logic             mode_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             c_q;
  logic             fail_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] first_q;

  logic             go;
  logic             step;
  logic             last;
  logic             mismatch;
  logic             pat_mode;
  logic [WIDTH:0]   golden;
  logic [IDX_W-1:0] k_nxt;
  logic [WIDTH-1:0] a_nxt;
  logic [WIDTH-1:0] b_nxt;
  logic             c_nxt;

  assign go       = bus.start && (state != RUN);
  assign step     = (state == RUN) && !bus.hold;
  assign last     = mode_q ? (k == '1) : (k == IDX_W'(7));
  assign golden   = {1'b0, a_q} + {1'b0, b_q} + (WIDTH + 1)'(c_q);
  assign mismatch = step && (bus.sum_in != golden);

  // The pattern register is loaded with the *next* index's pattern, so the
  // operand outputs stay purely registered.
  assign k_nxt    = go ? '0 : k + IDX_W'(1);
  assign pat_mode = go ? bus.mode : mode_q;

  always_comb begin
    a_nxt = '0;
    b_nxt = '0;
    c_nxt = k_nxt[0];
    if (pat_mode) begin
      b_nxt = k_nxt[WIDTH:1];
      a_nxt = k_nxt[2*WIDTH:WIDTH+1];
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (i % 2 == 0) begin
          a_nxt[i] = k_nxt[2];
          b_nxt[i] = k_nxt[1];
        end else begin
          a_nxt[i] = k_nxt[2] | (k_nxt[1] & ~k_nxt[0]);
          b_nxt[i] = (k_nxt[2] & (~k_nxt[1] | k_nxt[0])) | (k_nxt[1] & k_nxt[0]);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (bus.start) state_nxt = RUN;
      RUN:        if (step && last) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      k       <= '0;
      mode_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      fail_q  <= 1'b0;
      cnt_q   <= '0;
      first_q <= '0;
    end else if (go) begin
      k       <= '0;
      mode_q  <= bus.mode;
      a_q     <= a_nxt;
      b_q     <= b_nxt;
      c_q     <= c_nxt;
      fail_q  <= 1'b0;
      cnt_q   <= '0;
      first_q <= '0;
    end else if (step) begin
      if (mismatch) begin
        fail_q <= 1'b1;
        if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
        if (!fail_q) first_q <= k;
      end
      // Terminal index ends the run; k is left at its final value rather than wrapping.
      if (last) begin
        a_q <= '0;
        b_q <= '0;
        c_q <= 1'b0;
      end else begin
        k   <= k_nxt;
        a_q <= a_nxt;
        b_q <= b_nxt;
        c_q <= c_nxt;
      end
    end
  end

  assign bus.a              = a_q;
  assign bus.b              = b_q;
  assign bus.c_1            = c_q;
  assign bus.valid          = (state == RUN);
  assign bus.busy           = (state == RUN);
  assign bus.done           = (state == DONE);
  assign bus.fail           = fail_q;
  assign bus.fail_cnt       = cnt_q;
  assign bus.first_fail_idx = first_q;
endmodule
